imem_fetch: RTL and testbench

Parametrised single-port instruction memory with a valid/ready fetch interface, a program-load write port and address fault detection. It sits between the fetch stage's PC register and the decoder, replacing the fixed 32-word synchronous-read instruction store. It holds one response in an output register with back-pressure and supports a pipeline flush. It reports misaligned and out-of-range fetches instead of aliasing them.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_array.sv | 53 +++++
 rtl/imem_fetch.sv | 109 ++++++++++
 tb/tb_imem_fetch.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and helpers for the instruction fetch memory.
package imem_pkg;

  // Fault classification of a fetch request
  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_RANGE    = 2'd2;

  // Instruction returned on a faulting fetch
  localparam logic [63:0] NOP_INST = 64'd0;

  // Width of a word index for a memory of the given depth
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_W instruction storage: one synchronous write port and one
// synchronous read port whose output register doubles as the response data.
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32,
  localparam int unsigned IDX_W = idx_width(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  input  logic              rclr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Storage write port; contents are not touched by reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register next value: read, clear to NOP, or hold
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end else if (rclr_i) begin
      rdata_d = DATA_W'(NOP_INST);
    end
  end

  // Read register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch memory with valid/ready handshake, one-entry response
// register, flush, program-load port and address fault detection.
module imem_fetch
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned BYTE_ADDR = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_inst,
  output logic                     rsp_err,
  input  logic                     flush,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [DATA_W-1:0]        prog_data,
  output logic [15:0]              fault_cnt
);

  localparam int unsigned IDX_W = idx_width(DEPTH);

  logic [ADDR_W-1:0] idx;
  logic [1:0]        fault_code;
  logic              is_fault;
  logic              accept;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [15:0]       fault_cnt_q, fault_cnt_d;

  // Word index and fault classification of the presented address
  always_comb begin
    idx        = (BYTE_ADDR != 0) ? (req_addr >> 2) : req_addr;
    fault_code = FAULT_NONE;
    if ((BYTE_ADDR != 0) && (req_addr[1:0] != 2'b00)) begin
      fault_code = FAULT_MISALIGN;
    end else if ((idx >> IDX_W) != '0) begin
      fault_code = FAULT_RANGE;
    end
    is_fault = (fault_code != FAULT_NONE);
  end

  // Accept when no load, no flush and the response slot is free or draining
  always_comb begin
    req_ready = !prog_we && !flush && (!rsp_valid_q || rsp_ready);
    accept    = req_valid && req_ready;
  end

  // Response handshake and fault counter next state
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    fault_cnt_d = fault_cnt_q;
    if (flush) begin
      rsp_valid_d = 1'b0;
    end else if (accept) begin
      rsp_valid_d = 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    if (accept) begin
      rsp_err_d = is_fault;
    end
    if (accept && is_fault && (fault_cnt_q != 16'hFFFF)) begin
      fault_cnt_d = fault_cnt_q + 16'd1;
    end
  end

  // Response and counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      fault_cnt_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  // Storage; its read register holds the response instruction
  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i   (clock),
    .rst_i   (reset),
    .we_i    (prog_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .re_i    (accept && !is_fault),
    .raddr_i (idx[IDX_W-1:0]),
    .rclr_i  (accept && is_fault),
    .rdata_o (rsp_inst)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign fault_cnt = fault_cnt_q;

endmodule

// File: tb/tb_imem_fetch.sv
// Scoreboard bench for imem_fetch with directed and randomized traffic.
module tb_imem_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_inst;
  logic        rsp_err;
  logic        flush = 1'b0;
  logic        prog_we = 1'b0;
  logic [4:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic [15:0] fault_cnt;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] m_mem [32];
  logic        m_valid = 1'b0;
  int unsigned m_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  imem_fetch #(
    .ADDR_W    (64),
    .DATA_W    (32),
    .DEPTH     (32),
    .BYTE_ADDR (1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_inst  (rsp_inst),
    .rsp_err   (rsp_err),
    .flush     (flush),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .fault_cnt (fault_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: every visible response must match the oldest expected one
  always @(negedge clock) begin
    if (!reset && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected got=%h exp=none", rsp_inst);
      end else begin
        chk("rsp_inst", 64'(rsp_inst), 64'(exp_q[0].inst));
        chk("rsp_err", 64'(rsp_err), 64'(exp_q[0].err));
        if (rsp_ready || flush) void'(exp_q.pop_front());
      end
    end
  end

  // One clock cycle of stimulus, called just after a rising edge
  task automatic cycle(input logic rv, input logic [63:0] ra, input logic rr,
                       input logic fl, input logic pw, input logic [4:0] pa,
                       input logic [31:0] pd);
    logic exp_ready;
    logic acc;
    rsp_t e;
    req_valid = rv; req_addr = ra; rsp_ready = rr; flush = fl;
    prog_we = pw; prog_addr = pa; prog_data = pd;
    #2;
    exp_ready = !pw && !fl && (!m_valid || rr);
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    chk("fault_cnt", 64'(fault_cnt), 64'(m_cnt));
    acc = rv && exp_ready;
    if (acc) begin
      if ((ra % 64'd4) != 0 || (ra / 64'd4) >= 64'd32) begin
        e.inst = 32'd0;
        e.err  = 1'b1;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        e.inst = m_mem[5'(ra / 64'd4)];
        e.err  = 1'b0;
      end
      exp_q.push_back(e);
    end
    if (pw) m_mem[pa] = pd;
    if (fl)       m_valid = 1'b0;
    else if (acc) m_valid = 1'b1;
    else if (rr)  m_valid = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  // Asynchronous reset pulse, checked before the next clock edge
  task automatic reset_pulse();
    req_valid = 1'b0; flush = 1'b0; prog_we = 1'b0; rsp_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_inst", 64'(rsp_inst), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_fault_cnt", 64'(fault_cnt), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    exp_q.delete();
    m_valid = 1'b0;
    m_cnt = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  logic [63:0] ra;
  int          sel;
  logic [7:0]  init_words [4];

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
    init_words[0] = 8'h66; init_words[1] = 8'h60;
    init_words[2] = 8'h62; init_words[3] = 8'h63;
    @(posedge clock);
    #1;
    reset_pulse();

    // Program load then back-to-back fetches
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 5'(i), 32'(init_words[i]));
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 64'(i * 4), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    idle(1);

    // Misaligned and out-of-range faults
    cycle(1'b1, 64'h6, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 64'h80, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    idle(1);
    chk("fault_cnt_two", 64'(fault_cnt), 64'd2);

    // Back-pressure hold, then release
    cycle(1'b1, 64'd4, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'd8, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 64'd8, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    idle(1);

    // Load collides with a pending request to the same word
    cycle(1'b1, 64'd20, 1'b1, 1'b0, 1'b1, 5'd5, 32'h1234);
    cycle(1'b1, 64'd20, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    idle(1);

    // Flush a held response with a request present
    cycle(1'b1, 64'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 64'd4, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

    // Reset during a held response; memory survives
    cycle(1'b1, 64'd12, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    reset_pulse();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 64'(i * 4), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 64'd20, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    idle(1);

    // Fill the whole memory with random words
    for (int i = 0; i < 32; i++)
      cycle(1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 5'(i), $urandom);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       ra = 64'($urandom_range(0, 31)) * 64'd4;
      else if (sel == 7) ra = 64'($urandom_range(0, 31)) * 64'd4 + 64'($urandom_range(1, 3));
      else if (sel == 8) ra = {$urandom, $urandom} | 64'h80;
      else               ra = 64'd128 + 64'($urandom_range(0, 3)) * 64'd4;
      cycle(1'($urandom_range(0, 3) != 0), ra, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0),
            5'($urandom_range(0, 31)), $urandom);
    end

    idle(4);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
